branch_control_unit: RTL and testbench

//   Hardwired control sequencer that generates the datapath control strobes for instruction

---
 rtl/branch_control_unit.sv | 145 ++++++++++++++
 tb/tb_branch_control_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/branch_control_unit.sv
// branch_control_unit: hardwired fetch/branch/jump control sequencer for the DataPath
// Optional feature macro: CU_HALT_EN (halt opcode, stop request and resume port)
// Ports:
//   clock, clear_n (async active-low)   clock and reset
//   ir[31:0], con_ff                    instruction register and CON flip-flop
//   stop, resume (CU_HALT_EN only)      halt request / halt exit
//   PCout..R15in                        one-bit datapath strobes
//   ops[4:0]                            ALU operation select
//   run, illegal                        sequencing status, unsupported-opcode pulse
module branch_control_unit (
   input  logic        clock,
   input  logic        clear_n,
   input  logic [31:0] ir,
   input  logic        con_ff,
   input  logic        stop,
`ifdef CU_HALT_EN
   input  logic        resume,
`endif
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        RZin,
   output logic        RZLOout,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        gra,
   output logic        grb,
   output logic        grc,
   output logic        rin,
   output logic        rout,
   output logic        BAout,
   output logic        RYin,
   output logic        cout,
   output logic        conin,
   output logic        R15in,
   output logic [4:0]  ops,
   output logic        run,
   output logic        illegal
);
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] ALU_ADD = 5'b00011;
   localparam logic [3:0] S_RESET = 4'd0;
   localparam logic [3:0] S_T0    = 4'd1;
   localparam logic [3:0] S_T1    = 4'd2;
   localparam logic [3:0] S_T2    = 4'd3;
   localparam logic [3:0] S_T3    = 4'd4;
   localparam logic [3:0] S_T4    = 4'd5;
   localparam logic [3:0] S_T5    = 4'd6;
   localparam logic [3:0] S_T6    = 4'd7;
   localparam logic [3:0] S_HALT  = 4'd8;

   logic [3:0] state, nxt, done;
   logic [4:0] opcode;
   logic       t0, t1, t2, t3, t4, t5, t6;
   logic       is_br, is_jr, is_jal, is_nop, is_halt, known;
   logic       halt_req, resume_go;
   logic       unused_bits;

   assign opcode = ir[31:27];
   assign is_br  = opcode == OP_BR;
   assign is_jr  = opcode == OP_JR;
   assign is_jal = opcode == OP_JAL;
   assign is_nop = opcode == OP_NOP;

`ifdef CU_HALT_EN
   localparam logic [4:0] OP_HALT = 5'b11011;
   assign is_halt     = opcode == OP_HALT;
   assign halt_req    = stop;
   assign resume_go   = resume;
   assign unused_bits = ^ir[26:0];
`else
   // Without the halt feature the halt opcode falls through to the illegal path
   // and the HALT state has no way in, so leaving it simply restarts fetch.
   assign is_halt     = 1'b0;
   assign halt_req    = 1'b0;
   assign resume_go   = 1'b1;
   assign unused_bits = ^{ir[26:0], stop};
`endif

   assign known = is_br | is_jr | is_jal | is_nop | is_halt;

   assign t0 = state == S_T0;
   assign t1 = state == S_T1;
   assign t2 = state == S_T2;
   assign t3 = state == S_T3;
   assign t4 = state == S_T4;
   assign t5 = state == S_T5;
   assign t6 = state == S_T6;

   // Target after the final state of an instruction: a halt opcode or a pending
   // stop request parks the sequencer, otherwise the next fetch begins.
   assign done = (halt_req | (t3 & is_halt)) ? S_HALT : S_T0;

   always_comb begin
      nxt = S_RESET;
      case (state)
         S_RESET: nxt = S_T0;
         S_T0:    nxt = S_T1;
         S_T1:    nxt = S_T2;
         S_T2:    nxt = S_T3;
         S_T3:    nxt = (is_br | is_jal) ? S_T4 : done;
         S_T4:    nxt = is_jal ? done : S_T5;
         S_T5:    nxt = S_T6;
         S_T6:    nxt = done;
         S_HALT:  nxt = resume_go ? S_T0 : S_HALT;
         default: nxt = S_RESET;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n)
      if (!clear_n) state <= S_RESET;
      else          state <= nxt;

   // Strobes decode purely from state plus ir/con_ff, so an asynchronous clear
   // forces RESET and removes every strobe without waiting for a clock.
   assign PCout   = t0 | (t3 & is_jal) | (t4 & is_br);
   assign MARin   = t0;
   assign IncPC   = t0;
   assign RZin    = t0 | (t5 & is_br);
   assign RZLOout = t1 | t6;
   assign PCin    = t1 | (t3 & is_jr) | (t4 & is_jal) | (t6 & con_ff);
   assign Read    = t1;
   assign MDRin   = t1;
   assign MDRout  = t2;
   assign IRin    = t2;
   assign gra     = (t3 & (is_br | is_jr)) | (t4 & is_jal);
   assign rout    = (t3 & (is_br | is_jr)) | (t4 & is_jal);
   assign grb     = 1'b0;
   assign grc     = 1'b0;
   assign rin     = 1'b0;
   assign BAout   = 1'b0;
   assign RYin    = t4 & is_br;
   assign cout    = t5 & is_br;
   assign conin   = t3 & is_br;
   assign R15in   = t3 & is_jal;
   assign ops     = (t5 & is_br) ? ALU_ADD : 5'b00000;
   assign run     = t0 | t1 | t2 | t3 | t4 | t5 | t6;
   assign illegal = t3 & ~known;
endmodule

// File: tb/tb_branch_control_unit.sv
// tb_branch_control_unit: directed self-checking bench for branch_control_unit
module tb_branch_control_unit;
   localparam logic [19:0] PCO  = 20'h80000;
   localparam logic [19:0] MAR  = 20'h40000;
   localparam logic [19:0] INC  = 20'h20000;
   localparam logic [19:0] RZI  = 20'h10000;
   localparam logic [19:0] RZL  = 20'h08000;
   localparam logic [19:0] PCI  = 20'h04000;
   localparam logic [19:0] RD   = 20'h02000;
   localparam logic [19:0] MDI  = 20'h01000;
   localparam logic [19:0] MDO  = 20'h00800;
   localparam logic [19:0] IRI  = 20'h00400;
   localparam logic [19:0] GRA  = 20'h00200;
   localparam logic [19:0] ROUT = 20'h00020;
   localparam logic [19:0] RYI  = 20'h00008;
   localparam logic [19:0] COUT = 20'h00004;
   localparam logic [19:0] CONI = 20'h00002;
   localparam logic [19:0] R15  = 20'h00001;
   localparam logic [19:0] NONE = 20'h00000;

   logic        clock = 1'b0;
   logic        clear_n = 1'b1;
   logic [31:0] ir = 32'h0;
   logic        con_ff = 1'b0;
   logic        stop = 1'b0;
   logic        resume = 1'b0;
   logic        PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, MDRin, MDRout, IRin;
   logic        gra, grb, grc, rin, rout, BAout, RYin, cout, conin, R15in;
   logic [4:0]  ops;
   logic        run, illegal;
   int          tests = 0;
   int          fails = 0;

   branch_control_unit dut (
      .clock(clock), .clear_n(clear_n), .ir(ir), .con_ff(con_ff), .stop(stop),
`ifdef CU_HALT_EN
      .resume(resume),
`endif
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin), .RZLOout(RZLOout),
      .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
      .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .BAout(BAout),
      .RYin(RYin), .cout(cout), .conin(conin), .R15in(R15in),
      .ops(ops), .run(run), .illegal(illegal)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [19:0] s, input logic [4:0] o,
                      input logic r, input logic il);
      logic [26:0] obs, exp;
      obs = {PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, MDRin, MDRout, IRin,
             gra, grb, grc, rin, rout, BAout, RYin, cout, conin, R15in, ops, run, illegal};
      exp = {s, o, r, il};
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Checks T0 (current cycle), T1 and T2, leaving the sequencer in T3.
   task automatic fetch(input string tag);
      chk({tag, " T0"}, PCO | MAR | INC | RZI, 5'd0, 1'b1, 1'b0);
      tick();
      chk({tag, " T1"}, RZL | PCI | RD | MDI, 5'd0, 1'b1, 1'b0);
      tick();
      chk({tag, " T2"}, MDO | IRI, 5'd0, 1'b1, 1'b0);
      tick();
   endtask

   initial begin
      #2 clear_n = 1'b0;
      #1 chk("reset async", NONE, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset held", NONE, 5'd0, 1'b0, 1'b0);
      end
      clear_n = 1'b1;
      tick();
      // br taken
      ir = 32'h91800014;
      con_ff = 1'b1;
      fetch("br1");
      chk("br1 T3", GRA | ROUT | CONI, 5'd0, 1'b1, 1'b0);
      tick();
      chk("br1 T4", PCO | RYI, 5'd0, 1'b1, 1'b0);
      tick();
      chk("br1 T5", COUT | RZI, 5'b00011, 1'b1, 1'b0);
      tick();
      chk("br1 T6", RZL | PCI, 5'd0, 1'b1, 1'b0);
      tick();
      // br not taken
      con_ff = 1'b0;
      fetch("br0");
      chk("br0 T3", GRA | ROUT | CONI, 5'd0, 1'b1, 1'b0);
      tick();
      chk("br0 T4", PCO | RYI, 5'd0, 1'b1, 1'b0);
      tick();
      chk("br0 T5", COUT | RZI, 5'b00011, 1'b1, 1'b0);
      tick();
      chk("br0 T6", RZL, 5'd0, 1'b1, 1'b0);
      tick();
      // jr
      ir = 32'h9A800000;
      fetch("jr");
      chk("jr T3", GRA | ROUT | PCI, 5'd0, 1'b1, 1'b0);
      tick();
      // jal
      ir = 32'hA3000000;
      fetch("jal");
      chk("jal T3", PCO | R15, 5'd0, 1'b1, 1'b0);
      tick();
      chk("jal T4", GRA | ROUT | PCI, 5'd0, 1'b1, 1'b0);
      tick();
      // nop
      ir = 32'hD0000000;
      fetch("nop");
      chk("nop T3", NONE, 5'd0, 1'b1, 1'b0);
      tick();
      // unsupported opcode
      ir = 32'hF8000000;
      fetch("ill");
      chk("ill T3", NONE, 5'd0, 1'b1, 1'b1);
      tick();
`ifdef CU_HALT_EN
      ir = 32'hD8000000;
      fetch("halt");
      chk("halt T3", NONE, 5'd0, 1'b1, 1'b0);
      stop = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("halt parked", NONE, 5'd0, 1'b0, 1'b0);
      end
      stop = 1'b0;
      resume = 1'b1;
      tick();
      resume = 1'b0;
      // stop on the final br state diverts to HALT
      ir = 32'h91800014;
      con_ff = 1'b1;
      fetch("brs");
      tick();
      tick();
      tick();
      chk("brs T6", RZL | PCI, 5'd0, 1'b1, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("brs halt", NONE, 5'd0, 1'b0, 1'b0);
      tick();
      chk("brs hold", NONE, 5'd0, 1'b0, 1'b0);
      resume = 1'b1;
      tick();
      resume = 1'b0;
`else
      // halt opcode is illegal and stop is ignored when the feature is absent
      ir = 32'hD8000000;
      fetch("hlt");
      chk("hlt T3", NONE, 5'd0, 1'b1, 1'b1);
      tick();
      ir = 32'h91800014;
      con_ff = 1'b1;
      fetch("brs");
      tick();
      tick();
      tick();
      chk("brs T6", RZL | PCI, 5'd0, 1'b1, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
`endif
      // asynchronous clear during br T5
      ir = 32'h91800014;
      fetch("brc");
      tick();
      tick();
      chk("brc T5", COUT | RZI, 5'b00011, 1'b1, 1'b0);
      #2 clear_n = 1'b0;
      #1 chk("brc cleared", NONE, 5'd0, 1'b0, 1'b0);
      tick();
      chk("brc held", NONE, 5'd0, 1'b0, 1'b0);
      clear_n = 1'b1;
      tick();
      fetch("restart");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
